// File: rtl/turtle_debug_pkg.sv
// Shared types for the Turtle run-control / breakpoint unit.
// Optional retired-instruction counter: TURTLE_DBG_INSTRET_EN.
package turtle_debug_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } dbg_state_e;

  // Prefixed so the STEP cause does not collide with the STEP state.
  typedef enum logic [1:0] {
    HC_NONE = 2'd0,
    HC_REQ  = 2'd1,
    HC_STEP = 2'd2,
    HC_BP   = 2'd3
  } halt_cause_e;

  function automatic int bp_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turtle_debug_ctrl_bp.sv
// Breakpoint table, comparator bank and lowest-index priority encoder.
// Table is registered, so a write shows up in bp_match one cycle later.
module dbg_bp_unit
  import turtle_debug_pkg::*;
#(
  parameter int I_ADDR_W = 12,
  parameter int NUM_BP   = 4,
  parameter int BP_IDX_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [I_ADDR_W-1:0] pc,
  input  logic                bp_wr_en,
  input  logic [BP_IDX_W-1:0] bp_wr_idx,
  input  logic [I_ADDR_W-1:0] bp_wr_addr,
  input  logic                bp_wr_valid,
  output logic                bp_match,
  output logic [BP_IDX_W-1:0] bp_idx
);

  logic [I_ADDR_W-1:0] bp_addr [NUM_BP];
  logic [NUM_BP-1:0]   bp_arm;
  logic [NUM_BP-1:0]   hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_arm <= '0;
      for (int i = 0; i < NUM_BP; i++)
        bp_addr[i] <= '0;
    end else if (bp_wr_en && (int'(bp_wr_idx) < NUM_BP)) begin
      bp_arm[bp_wr_idx]  <= bp_wr_valid;
      bp_addr[bp_wr_idx] <= bp_wr_addr;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BP; i++)
      hit[i] = bp_arm[i] && (bp_addr[i] == pc);
  end

  // Scan high to low so the lowest matching entry is the last write.
  always_comb begin
    bp_match = 1'b0;
    bp_idx   = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (hit[i]) begin
        bp_match = 1'b1;
        bp_idx   = BP_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/turtle_debug_ctrl.sv
// Run/halt/step control, PC breakpoints and retired-instruction count.
// Counter present only when TURTLE_DBG_INSTRET_EN is defined.
module turtle_debug_ctrl
  import turtle_debug_pkg::*;
#(
  parameter int  I_ADDR_W      = 12,
  parameter int  NUM_BP        = 4,
  parameter int  CNT_W         = 32,
  parameter int  HALT_ON_RESET = 1,
  localparam int BP_IDX_W      = bp_idx_w(NUM_BP)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [I_ADDR_W-1:0] pc,
  input  logic                run_req,
  input  logic                halt_req,
  input  logic                step_req,
  input  logic                bp_wr_en,
  input  logic [BP_IDX_W-1:0] bp_wr_idx,
  input  logic [I_ADDR_W-1:0] bp_wr_addr,
  input  logic                bp_wr_valid,
  output logic                cpu_en,
  output logic                halted,
  output logic [1:0]          halt_cause,
  output logic [BP_IDX_W-1:0] bp_hit_idx,
  output logic [CNT_W-1:0]    instret
);

  localparam dbg_state_e RST_STATE =
    (HALT_ON_RESET != 0) ? ST_HALTED : ST_RUN;

  dbg_state_e          state, state_nx;
  halt_cause_e         cause, cause_nx;
  logic [BP_IDX_W-1:0] hit_idx, hit_nx;
  logic                skip, skip_nx;
  logic                bp_match;
  logic [BP_IDX_W-1:0] bp_idx;

  dbg_bp_unit #(
    .I_ADDR_W (I_ADDR_W),
    .NUM_BP   (NUM_BP),
    .BP_IDX_W (BP_IDX_W)
  ) u_bp (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .bp_wr_en    (bp_wr_en),
    .bp_wr_idx   (bp_wr_idx),
    .bp_wr_addr  (bp_wr_addr),
    .bp_wr_valid (bp_wr_valid),
    .bp_match    (bp_match),
    .bp_idx      (bp_idx)
  );

  // rst gates cpu_en directly so the core freezes without waiting a clock.
  assign cpu_en = !rst &&
    ((state == ST_STEP) ||
     ((state == ST_RUN) && !(bp_match && !skip)));

  assign halted     = (state == ST_HALTED);
  assign halt_cause = cause;
  assign bp_hit_idx = hit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      cause   <= HC_NONE;
      hit_idx <= '0;
      skip    <= 1'b0;
    end else begin
      state   <= state_nx;
      cause   <= cause_nx;
      hit_idx <= hit_nx;
      skip    <= skip_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cause_nx = cause;
    hit_nx   = hit_idx;
    skip_nx  = skip;
    unique case (state)
      ST_HALTED: begin
        if (step_req) begin
          state_nx = ST_STEP;
        end else if (run_req) begin
          state_nx = ST_RUN;
          skip_nx  = 1'b1;
        end
      end
      ST_RUN: begin
        if (bp_match && !skip) begin
          state_nx = ST_HALTED;
          cause_nx = HC_BP;
          hit_nx   = bp_idx;
        end else begin
          skip_nx = 1'b0;
          if (halt_req) begin
            state_nx = ST_HALTED;
            cause_nx = HC_REQ;
          end
        end
      end
      ST_STEP: begin
        state_nx = ST_HALTED;
        cause_nx = HC_STEP;
      end
      default: state_nx = RST_STATE;
    endcase
  end

`ifdef TURTLE_DBG_INSTRET_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (cpu_en)
      cnt <= cnt + CNT_W'(1);
  end

  assign instret = cnt;
`else
  assign instret = '0;
`endif

endmodule
